// File: rtl/overdrive_frame_sequencer.sv
// Per-frame controller: walks the input buffer, hands each sample to the
// overdrive effect through its START/DONE handshake, and writes the results back.
module overdrive_frame_sequencer #(
    parameter int FRAME_LEN = 1000,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              gain_sel,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              od_start,
    output logic              od_gain,
    output logic [15:0]       od_sample,
    input  logic              od_done,
    input  logic [15:0]       od_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, PROC, WB, FIN, ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  proc_cnt;

    // od_gain doubles as the latched per-frame gain
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            idx        <= '0;
            proc_cnt   <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_addr    <= '0;
            od_start   <= 1'b0;
            od_gain    <= 1'b0;
            od_sample  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            frame_done <= 1'b0;
            wr_en      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state      <= FETCH;
                        idx        <= '0;
                        rd_addr    <= '0;
                        od_gain    <= gain_sel;
                        frame_err  <= 1'b0;
                        frame_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    od_sample <= rd_data;
                    proc_cnt  <= '0;
                    od_start  <= 1'b1;
                    state     <= PROC;
                end
                PROC: begin
                    if (od_done) begin
                        od_start <= 1'b0;
                        wr_en    <= 1'b1;
                        wr_addr  <= idx;
                        wr_data  <= od_result;
                        state    <= WB;
                    end else if (proc_cnt == LAST_CNT) begin
                        od_start  <= 1'b0;
                        frame_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        proc_cnt <= proc_cnt + 1'b1;
                    end
                end
                WB: begin
                    if (idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state      <= FIN;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= FETCH;
                    end
                end
                FIN: begin
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
                ERR: begin
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overdrive_frame_sequencer.sv
// Bench for overdrive_frame_sequencer: buffer RAM and overdrive models,
// write/done scoreboard, vector table plus reset/timeout/back-to-back sequences.
module tb_overdrive_frame_sequencer;

    localparam int FL = 4;
    localparam int AW = 10;
    localparam int TO = 8;

    logic          CLK;
    logic          RESET;
    logic          frame_start;
    logic          gain_sel;
    logic          frame_busy;
    logic          frame_done;
    logic          frame_err;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          od_start;
    logic          od_gain;
    logic [15:0]   od_sample;
    logic          od_done;
    logic [15:0]   od_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    overdrive_frame_sequencer #(
        .FRAME_LEN(FL),
        .ADDR_W(AW),
        .TIMEOUT(TO)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .frame_start(frame_start),
        .gain_sel(gain_sel),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .od_start(od_start),
        .od_gain(od_gain),
        .od_sample(od_sample),
        .od_done(od_done),
        .od_result(od_result),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    typedef struct packed {
        logic            gain;
        logic            toggle;
        logic            pulse;
        logic [3:0][15:0] smp;
        logic [3:0][15:0] exp;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [31:0]   cyc;
    } wr_t;

    logic [15:0] mem [0:1023];
    logic        od_hang;
    wr_t         sb[$];
    int          done_q[$];
    vec_t        vecs[4];
    int          tests;
    int          fails;
    int          cyc;
    int          t0;
    int          done_cnt;
    logic        exp_gain;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) rd_data <= mem[rd_addr];

    // overdrive effect: DONE registered one cycle after START, wrapping multiply
    always @(posedge CLK) begin
        if (RESET) begin
            od_done   <= 1'b0;
            od_result <= '0;
        end else begin
            od_done   <= od_start & ~od_hang;
            od_result <= od_gain ? 16'($signed(od_sample) * 3)
                                 : 16'($signed(od_sample) * 2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int  rel;
        wr_t e;
        rel = cyc - t0;
        if (wr_en) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_wr: got addr %0d data %0h at %0d expected none",
                         wr_addr, wr_data, rel);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
                chk("wr_cycle", 64'(rel), 64'(e.cyc));
            end
        end
        if (frame_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got pulse at %0d expected none", rel);
            end else begin
                chk("done_cycle", 64'(rel), 64'(done_q.pop_front()));
            end
        end
        if (frame_busy)
            chk("od_gain", 64'(od_gain), 64'(exp_gain));
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        monitor();
    endtask

    function automatic logic [63:0] all_out();
        return 64'({frame_busy, frame_done, frame_err, rd_addr, od_start,
                    od_gain, od_sample, wr_en, wr_addr, wr_data});
    endfunction

    task automatic run_frame(input vec_t v);
        int d0;
        tick();
        for (int i = 0; i < FL; i++) mem[i] = v.smp[i];
        gain_sel    = v.gain;
        exp_gain    = v.gain;
        frame_start = 1'b1;
        t0          = cyc;
        for (int i = 0; i < FL; i++)
            sb.push_back('{addr: AW'(i), data: v.exp[i], cyc: 32'(5 + 5 * i)});
        done_q.push_back(5 * FL + 1);
        d0 = done_cnt;
        for (int k = 1; k <= 40 && done_cnt == d0; k++) begin
            tick();
            if (k == 1) begin
                frame_start = 1'b0;
                chk("err_cleared", 64'(frame_err), 64'(0));
                chk("busy_fetch", 64'(frame_busy), 64'(1));
            end
            if (v.toggle && k == 7) gain_sel = ~gain_sel;
            if (v.pulse && k == 8) frame_start = 1'b1;
            if (v.pulse && k == 9) frame_start = 1'b0;
        end
        chk("frame_done_seen", 64'(done_cnt - d0), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int d0;
        int err_at;
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        t0          = 0;
        done_cnt    = 0;
        exp_gain    = 1'b0;
        od_hang     = 1'b0;
        RESET       = 1'b1;
        frame_start = 1'b0;
        gain_sel    = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        vecs[0] = '{gain: 1'b0, toggle: 1'b0, pulse: 1'b0,
                    smp: {16'h0000, 16'h3FFF, 16'hFF38, 16'h0064},
                    exp: {16'h0000, 16'h7FFE, 16'hFE70, 16'h00C8}};
        vecs[1] = '{gain: 1'b1, toggle: 1'b1, pulse: 1'b1,
                    smp: {16'h03E8, 16'h03E8, 16'h03E8, 16'h03E8},
                    exp: {16'h0BB8, 16'h0BB8, 16'h0BB8, 16'h0BB8}};
        vecs[2] = '{gain: 1'b0, toggle: 1'b1, pulse: 1'b0,
                    smp: {16'h8000, 16'h7FFF, 16'hFFFF, 16'h4E20},
                    exp: {16'h0000, 16'hFFFE, 16'hFFFE, 16'h9C40}};
        vecs[3] = '{gain: 1'b1, toggle: 1'b0, pulse: 1'b1,
                    smp: {16'hD120, 16'h0007, 16'h2EE0, 16'hFFFB},
                    exp: {16'h7360, 16'h0015, 16'h8CA0, 16'hFFF1}};

        tick();
        tick();
        chk("reset_outputs", all_out(), 64'(0));
        RESET = 1'b0;
        tick();
        chk("idle_outputs", all_out(), 64'(0));

        for (int v = 0; v < 4; v++) run_frame(vecs[v]);

        // od_done never arrives: abort after TIMEOUT PROC cycles
        tick();
        od_hang     = 1'b1;
        gain_sel    = 1'b0;
        exp_gain    = 1'b0;
        frame_start = 1'b1;
        t0          = cyc;
        err_at      = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) frame_start = 1'b0;
            if (frame_err && err_at < 0) err_at = cyc - t0;
            if (k == 10) chk("to_start_high", 64'(od_start), 64'(1));
            if (k == 11) begin
                chk("to_err_busy", 64'(frame_busy), 64'(1));
                chk("to_start_low", 64'(od_start), 64'(0));
            end
        end
        chk("to_err_cycle", 64'(err_at), 64'(TO + 3));
        chk("to_err_sticky", 64'(frame_err), 64'(1));
        chk("to_idle", 64'(frame_busy), 64'(0));
        od_hang = 1'b0;
        run_frame(vecs[3]);

        // held frame_start: two frames with a single IDLE cycle between
        tick();
        for (int i = 0; i < FL; i++) mem[i] = vecs[0].smp[i];
        gain_sel    = 1'b0;
        exp_gain    = 1'b0;
        frame_start = 1'b1;
        t0          = cyc;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FL; i++)
                sb.push_back('{addr: AW'(i), data: vecs[0].exp[i],
                               cyc: 32'(5 + 5 * i + 22 * f)});
        done_q.push_back(21);
        done_q.push_back(43);
        d0 = done_cnt;
        for (int k = 1; k <= 80 && done_cnt - d0 < 2; k++) begin
            tick();
            if (k == 22) chk("b2b_gap_idle", 64'(frame_busy), 64'(0));
            if (k == 23) chk("b2b_refetch", 64'(frame_busy), 64'(1));
        end
        frame_start = 1'b0;
        chk("b2b_two_done", 64'(done_cnt - d0), 64'(2));
        chk("b2b_sb_drained", 64'(sb.size()), 64'(0));

        // reset in the middle of sample 1 processing
        tick();
        for (int i = 0; i < FL; i++) mem[i] = vecs[1].smp[i];
        gain_sel    = 1'b1;
        exp_gain    = 1'b1;
        frame_start = 1'b1;
        t0          = cyc;
        sb.push_back('{addr: AW'(0), data: 16'h0BB8, cyc: 32'(5)});
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) frame_start = 1'b0;
        end
        chk("pre_reset_proc", 64'(od_start), 64'(1));
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_reset_outputs", all_out(), 64'(0));
        end
        RESET = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        chk("post_reset_outputs", all_out(), 64'(0));
        chk("post_reset_sb", 64'(sb.size()), 64'(0));
        chk("post_reset_done_q", 64'(done_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
